dmem_boot_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of the data memory's boot port. It accepts a length-prefixed stream of bytes over a valid/ready handshake and assembles each group of four bytes into a 32-bit big-endian word. It writes consecutive words into data memory through `boot_daddr`/`boot_ddata`/`boot_dwe`, then holds the processor in reset until the image is fully written.

---
 rtl/dmem_boot_loader.sv | 142 ++++++++++++++
 tb/tb_dmem_boot_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_boot_loader.sv
// Boot loader: assembles a length-prefixed big-endian byte stream into 32-bit words,
// writes them to the data memory boot port and holds the CPU in reset until done.
module dmem_boot_loader #(
  parameter int DM_SIZE   = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic [31:0]          boot_daddr,
  output logic [31:0]          boot_ddata,
  output logic                 boot_dwe,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 cpu_resetn,
  output logic [CNT_WIDTH-1:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DM_LIMIT = CNT_WIDTH'(DM_SIZE);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q;
  logic [31:0]            word_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [CNT_WIDTH-1:0]   idx_q;

  logic                   accept;
  logic                   last_byte;
  logic                   start_ok;
  logic [31:0]            word_d;
  logic [CNT_WIDTH-1:0]   hdr_cnt;
  logic [CNT_WIDTH-1:0]   idx_inc;

  assign in_ready  = (state_q == S_HDR) || (state_q == S_DATA);
  assign busy      = in_ready || (state_q == S_WRITE);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt_q == 2'd3);
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Shifting in at the bottom lands byte 0 in bits 31:24 once four bytes are in.
  assign word_d    = {word_q[23:0], in_data};
  assign hdr_cnt   = word_d[CNT_WIDTH-1:0];
  assign idx_inc   = idx_q + ONE;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_HDR;
      S_HDR: begin
        if (last_byte) state_d = (hdr_cnt == '0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        if (last_byte) begin
          if (idx_q < DM_LIMIT)      state_d = S_WRITE;
          else if (idx_inc == count_q) state_d = S_DONE;
        end
      end
      S_WRITE: state_d = (idx_inc == count_q) ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: all datapath registers are reset; there is no storage array here that would
  // make a reset costly, and an aborted load must leave clean outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_cnt_q    <= '0;
      word_q        <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      boot_daddr    <= '0;
      boot_ddata    <= '0;
      boot_dwe      <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      cpu_resetn    <= 1'b0;
      words_written <= '0;
    end else begin
      boot_dwe <= (state_d == S_WRITE);

      if (start_ok) begin
        byte_cnt_q    <= '0;
        idx_q         <= '0;
        words_written <= '0;
        overflow      <= 1'b0;
        done          <= 1'b0;
        if (state_q == S_DONE) cpu_resetn <= 1'b0;
      end

      if (accept) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        word_q     <= word_d;
      end

      if ((state_q == S_HDR) && last_byte) begin
        count_q  <= hdr_cnt;
        overflow <= (hdr_cnt > DM_LIMIT);
      end

      if ((state_q == S_DATA) && last_byte) begin
        if (idx_q < DM_LIMIT) begin
          boot_ddata <= word_d;
          boot_daddr <= 32'(idx_q);
        end else begin
          idx_q <= idx_inc;
        end
      end

      if (state_q == S_WRITE) begin
        idx_q         <= idx_inc;
        words_written <= words_written + ONE;
      end

      // Entering DONE releases the CPU; a start taken in DONE goes to HDR instead.
      if (state_d == S_DONE) begin
        done       <= 1'b1;
        cpu_resetn <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Directed bench for dmem_boot_loader: a cycle table for the basic load plus
// hand-written sequences for zero count, bubbles, overflow and mid-load reset.
module tb_dmem_boot_loader;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready, boot_dwe, busy, done, overflow, cpu_resetn;
  logic [31:0] boot_daddr, boot_ddata;
  logic [15:0] words_written;

  logic        ov_in_ready, ov_boot_dwe, ov_busy, ov_done, ov_overflow, ov_cpu_resetn;
  logic [31:0] ov_boot_daddr, ov_boot_ddata;
  logic [15:0] ov_words_written;

  dmem_boot_loader #(.DM_SIZE(64), .CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .boot_daddr(boot_daddr), .boot_ddata(boot_ddata),
    .boot_dwe(boot_dwe), .busy(busy), .done(done), .overflow(overflow),
    .cpu_resetn(cpu_resetn), .words_written(words_written)
  );

  dmem_boot_loader #(.DM_SIZE(2), .CNT_WIDTH(16)) dut_ov (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ov_in_ready), .boot_daddr(ov_boot_daddr), .boot_ddata(ov_boot_ddata),
    .boot_dwe(ov_boot_dwe), .busy(ov_busy), .done(ov_done), .overflow(ov_overflow),
    .cpu_resetn(ov_cpu_resetn), .words_written(ov_words_written)
  );

  always #5 clk = ~clk;

  // Flags are {in_ready, busy, boot_dwe, done, cpu_resetn}.
  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [4:0]  flags;
    logic [15:0] ww;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t        vecs [16];
  logic [63:0] wq[$];
  logic [63:0] ov_wq[$];
  logic [7:0]  tx_q[$];
  int          checks = 0;
  int          errors = 0;
  int          viol = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [85:0] outs();
    return {in_ready, busy, boot_dwe, done, overflow, cpu_resetn,
            words_written, boot_daddr, boot_ddata};
  endfunction

  function automatic logic [85:0] ov_outs();
    return {ov_in_ready, ov_busy, ov_boot_dwe, ov_done, ov_overflow, ov_cpu_resetn,
            ov_words_written, ov_boot_daddr, ov_boot_ddata};
  endfunction

  // Capture every write strobe once, mid-cycle.
  always @(negedge clk) begin
    if (boot_dwe)    wq.push_back({boot_daddr, boot_ddata});
    if (ov_boot_dwe) ov_wq.push_back({ov_boot_daddr, ov_boot_ddata});
    if ((boot_dwe && in_ready) || (ov_boot_dwe && ov_in_ready)) viol++;
  end

  task automatic init_vecs();
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 5'b00000, 16'd0, 32'd0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 5'b11000, 16'd0, 32'd0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 8'h00, 5'b11000, 16'd0, 32'd0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 5'b11000, 16'd0, 32'd0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 8'h02, 5'b11000, 16'd0, 32'd0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 8'h11, 5'b11000, 16'd0, 32'd0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 8'h22, 5'b11000, 16'd0, 32'd0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 8'h33, 5'b11000, 16'd0, 32'd0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 8'h44, 5'b11000, 16'd0, 32'd0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 8'hAA, 5'b01100, 16'd0, 32'd0, 32'h11223344};
    vecs[10] = '{1'b0, 1'b1, 8'hAA, 5'b11000, 16'd1, 32'd0, 32'h11223344};
    vecs[11] = '{1'b0, 1'b1, 8'hBB, 5'b11000, 16'd1, 32'd0, 32'h11223344};
    vecs[12] = '{1'b0, 1'b1, 8'hCC, 5'b11000, 16'd1, 32'd0, 32'h11223344};
    vecs[13] = '{1'b0, 1'b1, 8'hDD, 5'b11000, 16'd1, 32'd0, 32'h11223344};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 5'b01100, 16'd1, 32'd1, 32'hAABBCCDD};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 5'b00011, 16'd2, 32'd1, 32'hAABBCCDD};
  endtask

  // Cycle-exact basic load from IDLE, with start pulses in HDR, DATA and WRITE.
  task automatic run_table(input string tag);
    logic [85:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start    = vecs[i].start;
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      #1;
      exp = {vecs[i].flags[4], vecs[i].flags[3], vecs[i].flags[2], vecs[i].flags[1],
             1'b0, vecs[i].flags[0], vecs[i].ww, vecs[i].addr, vecs[i].wdata};
      check($sformatf("%s_c%0d", tag, i), 128'(outs()), 128'(exp));
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[31:24]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  // Offer tx_q bytes with in_valid following pat[k%4]; returns at the negedge
  // following the last accept.
  task automatic run_stream(input logic [3:0] pat, input bit use_ov);
    int k = 0;
    bit acc;
    while (tx_q.size() > 0 && k < 400) begin
      @(negedge clk);
      in_valid = pat[k % 4];
      in_data  = tx_q[0];
      #1;
      acc = in_valid && (use_ov ? ov_in_ready : in_ready);
      @(posedge clk);
      if (acc) void'(tx_q.pop_front());
      k++;
    end
    check("stream_drained", 128'(tx_q.size()), 128'(0));
    tx_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input bit use_ov);
    int n = 0;
    while (!(use_ov ? ov_done : done) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_within_budget", 128'(use_ov ? ov_done : done), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    init_vecs();
    #3 resetn = 1'b0;
    #1;
    check("reset_outs", 128'(outs()), 128'(0));
    check("reset_ov_outs", 128'(ov_outs()), 128'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run_table("basic");

    // Repeated start from DONE, then a zero-length image.
    do_start();
    check("restart_from_done", 128'({cpu_resetn, done, in_ready}), 128'(3'b001));
    wq.delete();
    push_word(32'h0000_0000);
    run_stream(4'b1111, 1'b0);
    check("zero_count_outs", 128'(outs()),
          128'({6'b000101, 16'd0, 32'd1, 32'hAABBCCDD}));
    check("zero_count_writes", 128'(wq.size()), 128'(0));

    // Bubbles on in_valid: 1-0-0-1.
    do_start();
    wq.delete();
    push_word(32'd2);
    push_word(32'h11223344);
    push_word(32'hAABBCCDD);
    run_stream(4'b1001, 1'b0);
    wait_done(1'b0);
    check("bubble_nwrites", 128'(wq.size()), 128'(2));
    check("bubble_w0", 128'(wq[0]), 128'({32'd0, 32'h11223344}));
    check("bubble_w1", 128'(wq[1]), 128'({32'd1, 32'hAABBCCDD}));
    check("bubble_ww_cpu", 128'({words_written, cpu_resetn}), 128'({16'd2, 1'b1}));

    // Overflow on the DM_SIZE=2 instance; the deep instance sees the same stream.
    do_start();
    wq.delete();
    ov_wq.delete();
    push_word(32'd3);
    run_stream(4'b1111, 1'b1);
    check("ovf_after_hdr", 128'({ov_overflow, overflow}), 128'(2'b10));
    push_word(32'h11223344);
    push_word(32'hAABBCCDD);
    push_word(32'h55667788);
    run_stream(4'b1111, 1'b1);
    wait_done(1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("ovf_nwrites", 128'(ov_wq.size()), 128'(2));
    check("ovf_w0", 128'(ov_wq[0]), 128'({32'd0, 32'h11223344}));
    check("ovf_w1", 128'(ov_wq[1]), 128'({32'd1, 32'hAABBCCDD}));
    check("ovf_final", 128'({ov_words_written, ov_done, ov_overflow, ov_cpu_resetn}),
          128'({16'd2, 3'b111}));
    check("deep_final", 128'({words_written, overflow, boot_daddr, boot_ddata}),
          128'({16'd3, 1'b0, 32'd2, 32'h55667788}));

    // Reset after two data bytes, then a clean basic load.
    do_start();
    wq.delete();
    ov_wq.delete();
    push_word(32'd2);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    run_stream(4'b1111, 1'b0);
    resetn = 1'b0;
    #1;
    check("midreset_outs", 128'(outs()), 128'(0));
    check("midreset_ov_outs", 128'(ov_outs()), 128'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("midreset_no_write", 128'(wq.size() + ov_wq.size()), 128'(0));
    check("midreset_idle", 128'(outs()), 128'(0));
    run_table("reload");

    check("dwe_while_ready", 128'(viol), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
